bcd_serial_adder: RTL and testbench

//  Multi-digit packed-BCD adder. Adds two DIGITS-wide BCD operands one decimal

---
 rtl/bcd_serial_adder_pkg.sv | 13 +
 rtl/bcd_serial_adder_digit_step.sv | 30 +++
 rtl/bcd_serial_adder.sv | 128 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial packed-BCD adder.
package bcd_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [4:0] BCD_ADJ = 5'd6;

endpackage

// File: rtl/bcd_serial_adder_digit_step.sv
// Single-digit BCD adder stage: binary add, then decimal correction when the sum exceeds 9.
module bcd_digit_step
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       c_in,
    output logic [3:0] digit,
    output logic       c_out,
    output logic       invalid
);

    logic [4:0] bin_sum;
    logic [4:0] adj_sum;

    always_comb begin
        bin_sum = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c_in};
        adj_sum = bin_sum + BCD_ADJ;
        invalid = (a_d > BCD_MAX) || (b_d > BCD_MAX);
        // Out-of-range digits take the same correction path; err reports them instead.
        if (bin_sum > {1'b0, BCD_MAX}) begin
            digit = adj_sum[3:0];
            c_out = 1'b1;
        end else begin
            digit = bin_sum[3:0];
            c_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, least-significant digit first.
//  state   | meaning
//  ST_IDLE | waiting for start; result ports hold the last result
//  ST_RUN  | adding digit idx_q, carry kept in carry_q between digits
//  ST_DONE | one-cycle done pulse, returns to ST_IDLE unconditionally
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;

    logic [3:0]    a_dig, b_dig, step_digit;
    logic          step_carry, step_invalid;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
    end

    bcd_digit_step u_step (
        .a_d     (a_dig),
        .b_d     (b_dig),
        .c_in    (carry_q),
        .digit   (step_digit),
        .c_out   (step_carry),
        .invalid (step_invalid)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) sum_d[4*i +: 4] = step_digit;
                end
                carry_d = step_carry;
                err_d   = err_q | step_invalid;
                if (idx_q == LAST_IDX) begin
                    cout_d  = step_carry;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scenario bench for bcd_serial_adder (DIGITS=4) with an expected-result queue.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, err;
    logic [15:0] sum;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Decimal reference for operands with valid digits only.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
        exp_t r;
        int da = 0, db = 0, total, t;
        for (int i = 3; i >= 0; i--) begin
            da = da * 10 + int'(ma[4*i +: 4]);
            db = db * 10 + int'(mb[4*i +: 4]);
        end
        total  = da + db + int'(mc);
        r.cout = (total >= 10000);
        t      = total % 10000;
        r.sum  = '0;
        for (int i = 0; i < 4; i++) begin
            r.sum[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        r.err = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Issue one operation from IDLE and wait (bounded) for done; inputs are scrambled after accept.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          output int lat, output bit seen);
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hFFFF; b = 16'hAAAA; cin = ~tc;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, sum, cout, err} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=00000", {busy, done, sum, cout, err});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va[4] = '{16'h1234, 16'h9999, 16'h9999, 16'h12A4};
        logic [15:0] vb[4] = '{16'h5678, 16'h0001, 16'h9999, 16'h0000};
        logic        vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_t e;
        int lat;
        bit seen;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back(exp_t'{sum: 16'h1304, cout: 1'b0, err: 1'b1});
            else        exp_q.push_back(model(va[k], vb[k], vc[k]));
            run_op(va[k], vb[k], vc[k], lat, seen);
            checks++;
            if (!seen) begin
                failures++;
                $display("FAIL vec%0d_timeout done not seen within 20 cycles", k);
                void'(exp_q.pop_front());
                continue;
            end
            e = exp_q.pop_front();
            checks++;
            if ({sum, cout, err} !== {e.sum, e.cout, e.err}) begin
                failures++;
                $display("FAIL vec%0d_result got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
                         k, sum, cout, err, e.sum, e.cout, e.err);
            end
            checks++;
            if (lat !== DIGITS || busy !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_latency got lat=%0d busy=%b want lat=%0d busy=1", k, lat, busy, DIGITS);
            end
            @(posedge clk); #1;
            checks++;
            if ({busy, done} !== 2'b00 || sum !== e.sum) begin
                failures++;
                $display("FAIL vec%0d_after_done got busy=%b done=%b sum=%h want 0 0 %h", k, busy, done, sum, e.sum);
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int lat;
        bit seen;
        e = model(16'h0457, 16'h0368, 1'b0);
        exp_q.push_back(e);
        @(posedge clk); #1;
        a = 16'h0457; b = 16'h0368; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b1;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen || lat !== DIGITS) begin
            failures++;
            $display("FAIL ignore_done_timing got seen=%b lat=%0d want seen=1 lat=%0d", seen, lat, DIGITS);
        end
        e = exp_q.pop_front();
        checks++;
        if ({sum, cout, err} !== {e.sum, e.cout, e.err}) begin
            failures++;
            $display("FAIL ignore_result got sum=%h cout=%b want sum=%h cout=%b", sum, cout, e.sum, e.cout);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, done} !== 2'b00 || sum !== e.sum) begin
                failures++;
                $display("FAIL ignore_idle%0d got busy=%b done=%b sum=%h want 0 0 %h", i, busy, done, sum, e.sum);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        bit seen;
        exp_q.push_back(model(16'h0815, 16'h4711, 1'b1));
        exp_q.push_back(model(16'h5000, 16'h5000, 1'b0));
        @(posedge clk); #1;
        a = 16'h0815; b = 16'h4711; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h5000; b = 16'h5000; cin = 1'b0;
        for (int op = 0; op < 2; op++) begin
            lat = 0; seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clk); #1;
                lat++;
                if (done) seen = 1'b1;
            end
            e = exp_q.pop_front();
            checks++;
            if (!seen || lat !== ((op == 0) ? DIGITS : DIGITS + 2)) begin
                failures++;
                $display("FAIL b2b%0d_timing got seen=%b lat=%0d want seen=1 lat=%0d",
                         op, seen, lat, (op == 0) ? DIGITS : DIGITS + 2);
            end
            checks++;
            if ({sum, cout, err} !== {e.sum, e.cout, e.err}) begin
                failures++;
                $display("FAIL b2b%0d_result got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
                         op, sum, cout, err, e.sum, e.cout, e.err);
            end
            if (op == 1) start = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int lat;
        bit seen;
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sum[3:0] !== 4'h2) begin
            failures++;
            $display("FAIL midrun_first_digit got %h want 2", sum[3:0]);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, err} !== 20'h0) begin
            failures++;
            $display("FAIL midrun_reset_outputs got=%h want=00000", {busy, done, sum, cout, err});
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midrun_no_done got done=1 want 0");
        end
        @(negedge clk); rst_n = 1'b1;
        e = model(16'h2468, 16'h7531, 1'b1);
        exp_q.push_back(e);
        run_op(16'h2468, 16'h7531, 1'b1, lat, seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen || {sum, cout, err} !== {e.sum, e.cout, e.err}) begin
            failures++;
            $display("FAIL midrun_recover got seen=%b sum=%h cout=%b want seen=1 sum=%h cout=%b",
                     seen, sum, cout, e.sum, e.cout);
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [15:0] ra, rb;
        logic rc;
        int lat;
        bit seen;
        for (int k = 0; k < 8; k++) begin
            ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom_range(0, 1));
            exp_q.push_back(model(ra, rb, rc));
            run_op(ra, rb, rc, lat, seen);
            e = exp_q.pop_front();
            checks++;
            if (!seen || {sum, cout, err} !== {e.sum, e.cout, e.err}) begin
                failures++;
                $display("FAIL rand%0d a=%h b=%h cin=%b got seen=%b sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
                         k, ra, rb, rc, seen, sum, cout, err, e.sum, e.cout, e.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
